// File: rtl/mac_stop_pkg.sv
// Shared types for the matrix-core stop/sequencer: FSM state encoding and
// default geometry, plus the address-width helper used to size element addresses.
package mac_stop_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_LOAD_A,
        S_LOAD_B,
        S_SEND_DONE,
        S_WAIT_MAC,
        S_WAIT_RES,
        S_RD_REQ,
        S_RD_CAP,
        S_RD_OUT,
        S_FINISH
    } state_t;

    localparam int DEF_M     = 4;
    localparam int DEF_K     = 4;
    localparam int DEF_N     = 4;
    localparam int DEF_DW_IN = 32;

    // A one-entry dimension still needs a 1-bit address port.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_stop_seq_idx_cnt.sv
// Row/column element counter: column advances first, wrapping to 0 with row+1;
// the last element wraps the whole counter back to (0,0).
module mac_stop_idx_cnt
    import mac_stop_pkg::*;
#(
    parameter int ROWS = DEF_M,
    parameter int COLS = DEF_K,
    parameter int RW   = addr_w(DEF_M),
    parameter int CW   = addr_w(DEF_K)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr,
    input  logic          adv,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          row_end;
    logic          col_end;

    assign row_end = (row_q == RW'(ROWS - 1));
    assign col_end = (col_q == CW'(COLS - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = row_end & col_end;

endmodule

// File: rtl/mac_stop_seq.sv
// Job sequencer around an external matrix-multiply core: streams A then B into
// the core's matrix stores, waits for the result, then reads C out row-major.
module mac_stop_seq
    import mac_stop_pkg::*;
#(
    parameter int  M      = DEF_M,
    parameter int  K      = DEF_K,
    parameter int  N      = DEF_N,
    parameter int  DW_IN  = DEF_DW_IN,
    parameter int  DW_OUT = 2 * DW_IN + $clog2(K),
    localparam int AW_M   = addr_w(M),
    localparam int AW_K   = addr_w(K),
    localparam int AW_N   = addr_w(N)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    output logic              busy,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [DW_IN-1:0]  in_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [DW_OUT-1:0] out_data,
    output logic              host2block_val,
    input  logic              host2block_rdy,
    output logic              done_sending_data,
    input  logic              mac_done,
    input  logic              block2host_val,
    output logic              block2host_rdy,
    input  logic              start_reading_result_matrix,
    output logic              done_reading_result_matrix,
    output logic [DW_IN-1:0]  ext_data_in_a,
    output logic [DW_IN-1:0]  ext_data_in_b,
    output logic [AW_M-1:0]   ext_row_addr_a,
    output logic [AW_K-1:0]   ext_col_addr_a,
    output logic [AW_K-1:0]   ext_row_addr_b,
    output logic [AW_N-1:0]   ext_col_addr_b,
    output logic [AW_M-1:0]   ext_row_addr_c,
    output logic [AW_N-1:0]   ext_col_addr_c,
    output logic              ext_matrix_a_we,
    output logic              ext_matrix_b_we,
    output logic              ext_matrix_c_re,
    input  logic [DW_OUT-1:0] ext_data_out_c
);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              in_rdy_q, in_rdy_d;
    logic              h2b_val_q, h2b_val_d;
    logic              dsend_q, dsend_d;
    logic              wres_q, wres_d;
    logic              c_re_q, c_re_d;
    logic              out_val_q, out_val_d;
    logic              drd_q, drd_d;
    logic [DW_OUT-1:0] c_q, c_d;

    logic a_beat, b_beat, c_adv;
    logic a_last, b_last, c_last;
    logic clr_a, clr_b, clr_c;

    // A write happens only on an accepted upstream beat in the matching phase.
    assign a_beat = (state_q == S_LOAD_A) & in_rdy_q & in_val;
    assign b_beat = (state_q == S_LOAD_B) & in_rdy_q & in_val;
    assign c_adv  = (state_q == S_RD_OUT) & out_rdy;

    assign clr_a = ((state_q == S_REQ) & host2block_rdy) | (state_q == S_FINISH);
    assign clr_b = (a_beat & a_last) | (state_q == S_FINISH);
    assign clr_c = ((state_q == S_WAIT_RES) & start_reading_result_matrix)
                 | (state_q == S_FINISH);

    mac_stop_idx_cnt #(.ROWS(M), .COLS(K), .RW(AW_M), .CW(AW_K)) u_cnt_a (
        .clk(clk), .resetn(resetn), .clr(clr_a), .adv(a_beat),
        .row(ext_row_addr_a), .col(ext_col_addr_a), .last(a_last)
    );

    mac_stop_idx_cnt #(.ROWS(K), .COLS(N), .RW(AW_K), .CW(AW_N)) u_cnt_b (
        .clk(clk), .resetn(resetn), .clr(clr_b), .adv(b_beat),
        .row(ext_row_addr_b), .col(ext_col_addr_b), .last(b_last)
    );

    mac_stop_idx_cnt #(.ROWS(M), .COLS(N), .RW(AW_M), .CW(AW_N)) u_cnt_c (
        .clk(clk), .resetn(resetn), .clr(clr_c), .adv(c_adv),
        .row(ext_row_addr_c), .col(ext_col_addr_c), .last(c_last)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        unique case (state_q)
            S_IDLE:      if (start) state_d = S_REQ;
            S_REQ:       if (host2block_rdy) state_d = S_LOAD_A;
            S_LOAD_A:    if (a_beat && a_last) state_d = S_LOAD_B;
            S_LOAD_B:    if (b_beat && b_last) state_d = S_SEND_DONE;
            S_SEND_DONE: state_d = S_WAIT_MAC;
            S_WAIT_MAC:  if (mac_done) state_d = S_WAIT_RES;
            S_WAIT_RES:  if (start_reading_result_matrix) state_d = S_RD_REQ;
            S_RD_REQ:    state_d = S_RD_CAP;
            S_RD_CAP: begin
                c_d     = ext_data_out_c;
                state_d = S_RD_OUT;
            end
            S_RD_OUT:    if (out_rdy) state_d = c_last ? S_FINISH : S_RD_REQ;
            S_FINISH:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        // Control outputs are decoded from the next state so they are flops.
        busy_d    = (state_d != S_IDLE);
        in_rdy_d  = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
        h2b_val_d = (state_d == S_REQ);
        dsend_d   = (state_d == S_SEND_DONE);
        wres_d    = (state_d == S_WAIT_RES);
        c_re_d    = (state_d == S_RD_REQ);
        out_val_d = (state_d == S_RD_OUT);
        drd_d     = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            in_rdy_q  <= 1'b0;
            h2b_val_q <= 1'b0;
            dsend_q   <= 1'b0;
            wres_q    <= 1'b0;
            c_re_q    <= 1'b0;
            out_val_q <= 1'b0;
            drd_q     <= 1'b0;
            c_q       <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            in_rdy_q  <= in_rdy_d;
            h2b_val_q <= h2b_val_d;
            dsend_q   <= dsend_d;
            wres_q    <= wres_d;
            c_re_q    <= c_re_d;
            out_val_q <= out_val_d;
            drd_q     <= drd_d;
            c_q       <= c_d;
        end
    end

    assign busy                       = busy_q;
    assign in_rdy                     = in_rdy_q;
    assign out_val                    = out_val_q;
    assign out_data                   = c_q;
    assign host2block_val             = h2b_val_q;
    assign done_sending_data          = dsend_q;
    assign block2host_rdy             = wres_q & block2host_val;
    assign done_reading_result_matrix = drd_q;
    assign ext_matrix_a_we            = a_beat;
    assign ext_matrix_b_we            = b_beat;
    assign ext_matrix_c_re            = c_re_q;
    assign ext_data_in_a              = a_beat ? in_data : '0;
    assign ext_data_in_b              = b_beat ? in_data : '0;

endmodule
